// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core pipeline: memory-access FSM encoding,
// error-flag bit positions and the register-address width.
package core_pkg;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_TIMEOUT  = 1;
    localparam int RegAddrW     = 5;

endpackage

// File: rtl/ex_mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/dmem_wait_timer.sv
// Counts WAIT cycles without ack and flags the cycle in which an access must be abandoned.
module dmem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    input  logic en,
    output logic tmo
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;

    // TIMEOUT==0 disables the abort; the counter then simply wraps.
    assign tmo = (TIMEOUT != 0) & en & (wait_cnt == LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt <= '0;
        end else if (clr || tmo) begin
            wait_cnt <= '0;
        end else if (en) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM register, data-memory req/ack controller and MEM/WB register of the RV32 core.
// Stalls upstream while an aligned load/store waits for ack or timeout.
module ex_mem_stage
    import core_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                ex_valid_i,
    input  logic [DATA_W-1:0]   ex_alu_res_i,
    input  logic [DATA_W-1:0]   ex_rs2_data_i,
    input  logic [RegAddrW-1:0] ex_rd_addr_i,
    input  logic                ex_regwrite_i,
    input  logic                ex_memread_i,
    input  logic                ex_memwrite_i,
    input  logic                ex_memtoreg_i,
    output logic                mem_stall_o,
    output logic                MEM_RegWrite,
    output logic [RegAddrW-1:0] MEM_rd_addr,
    output logic [DATA_W-1:0]   MEM_fwd_data,
    output logic                WB_RegWrite,
    output logic [RegAddrW-1:0] WB_rd_addr,
    output logic [DATA_W-1:0]   WB_data,
    ex_mem_stage_if.master      dmem,
    output logic [1:0]          err_o
);

    mem_state_e          state;
    logic                vld_p0, regwrite_p0, memread_p0, memwrite_p0, memtoreg_p0;
    logic [DATA_W-1:0]   alu_p0, rs2_p0;
    logic [RegAddrW-1:0] rd_p0;
    logic                vld_p1, regwrite_p1;
    logic [RegAddrW-1:0] rd_p1;
    logic [DATA_W-1:0]   data_p1;

    logic in_wait, ack, tmo, stall, memop, misalign, fault, ex_go;

    assign in_wait  = (state == MEM_WAIT);
    assign ack      = in_wait & dmem.ack;
    assign stall    = in_wait & ~dmem.ack & ~tmo;
    assign memop    = vld_p0 & (memread_p0 | memwrite_p0);
    assign misalign = memop & (alu_p0[1:0] != 2'b00);
    assign fault    = misalign | tmo;
    assign ex_go    = ex_valid_i & (ex_memread_i | ex_memwrite_i) & (ex_alu_res_i[1:0] == 2'b00);

    dmem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (~in_wait | ack),
        .en      (in_wait & ~dmem.ack),
        .tmo     (tmo)
    );

    // A misaligned op never enters WAIT, so it retires after a single MEM cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= MEM_IDLE;
        end else if (!stall) begin
            state <= ex_go ? MEM_WAIT : MEM_IDLE;
        end
    end

    // EX -> MEM boundary
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p0      <= 1'b0;
            regwrite_p0 <= 1'b0;
            memread_p0  <= 1'b0;
            memwrite_p0 <= 1'b0;
            memtoreg_p0 <= 1'b0;
            alu_p0      <= '0;
            rs2_p0      <= '0;
            rd_p0       <= '0;
        end else if (!stall) begin
            vld_p0      <= ex_valid_i;
            regwrite_p0 <= ex_regwrite_i;
            memread_p0  <= ex_memread_i;
            memwrite_p0 <= ex_memwrite_i;
            memtoreg_p0 <= ex_memtoreg_i;
            alu_p0      <= ex_alu_res_i;
            rs2_p0      <= ex_rs2_data_i;
            rd_p0       <= ex_rd_addr_i;
        end
    end

    // MEM -> WB boundary
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1      <= 1'b0;
            regwrite_p1 <= 1'b0;
            rd_p1       <= '0;
            data_p1     <= '0;
            err_o       <= 2'b00;
        end else begin
            vld_p1      <= vld_p0 & ~stall;
            regwrite_p1 <= regwrite_p0 & ~fault;
            rd_p1       <= rd_p0;
            data_p1     <= tmo ? '0 : (memtoreg_p0 ? dmem.rdata : alu_p0);
            if (misalign) err_o[ERR_MISALIGN] <= 1'b1;
            if (tmo)      err_o[ERR_TIMEOUT]  <= 1'b1;
        end
    end

    assign mem_stall_o  = stall;
    assign MEM_RegWrite = vld_p0 & regwrite_p0;
    assign MEM_rd_addr  = rd_p0;
    assign MEM_fwd_data = alu_p0;
    assign WB_RegWrite  = vld_p1 & regwrite_p1;
    assign WB_rd_addr   = rd_p1;
    assign WB_data      = data_p1;

    assign dmem.req   = in_wait;
    assign dmem.we    = memwrite_p0;
    assign dmem.addr  = ADDR_W'(alu_p0);
    assign dmem.wdata = rs2_p0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus a randomized run against a transaction-level model.
module tb_ex_mem_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TMO    = 4;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rw, mr, mw, mt;
        int          lat;
    } instr_t;

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata, rdata;
        int          lat;
    } txn_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
    logic [DATA_W-1:0] ex_alu_res, ex_rs2_data;
    logic [4:0]        ex_rd_addr;
    logic              mem_stall, mem_regwrite, wb_regwrite;
    logic [4:0]        mem_rd_addr, wb_rd_addr;
    logic [DATA_W-1:0] mem_fwd_data, wb_data;
    logic [1:0]        err;

    int checks = 0;
    int errors = 0;

    ex_mem_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dmem ();

    ex_mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TMO)) u_dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .ex_valid_i    (ex_valid),
        .ex_alu_res_i  (ex_alu_res),
        .ex_rs2_data_i (ex_rs2_data),
        .ex_rd_addr_i  (ex_rd_addr),
        .ex_regwrite_i (ex_regwrite),
        .ex_memread_i  (ex_memread),
        .ex_memwrite_i (ex_memwrite),
        .ex_memtoreg_i (ex_memtoreg),
        .mem_stall_o   (mem_stall),
        .MEM_RegWrite  (mem_regwrite),
        .MEM_rd_addr   (mem_rd_addr),
        .MEM_fwd_data  (mem_fwd_data),
        .WB_RegWrite   (wb_regwrite),
        .WB_rd_addr    (wb_rd_addr),
        .WB_data       (wb_data),
        .dmem          (dmem),
        .err_o         (err)
    );

    function automatic instr_t mk(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                                  input logic [4:0] rd, input logic rw, input logic mr,
                                  input logic mw, input logic mt);
        instr_t i;
        i.valid = v; i.alu = alu; i.rs2 = rs2; i.rd = rd;
        i.rw = rw; i.mr = mr; i.mw = mw; i.mt = mt; i.lat = 1;
        return i;
    endfunction

    function automatic instr_t gen();
        instr_t i;
        int op, r;
        i.valid = ($urandom_range(0, 4) != 0);
        op      = $urandom_range(0, 2);
        i.rs2   = $urandom;
        i.rd    = 5'($urandom);
        i.rw    = 1'($urandom);
        i.alu   = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
        if ($urandom_range(0, 5) == 0) i.alu = i.alu + 32'($urandom_range(1, 3));
        i.mr = (op == 1); i.mw = (op == 2); i.mt = (op == 1);
        if (op == 0) i.alu = $urandom;
        r = $urandom_range(0, 9);
        i.lat = (r < 7) ? $urandom_range(1, 3) : ((r == 7) ? TMO : 99);
        return i;
    endfunction

    task automatic drive_ex(input instr_t i);
        ex_valid = i.valid; ex_alu_res = i.alu; ex_rs2_data = i.rs2; ex_rd_addr = i.rd;
        ex_regwrite = i.rw; ex_memread = i.mr; ex_memwrite = i.mw; ex_memtoreg = i.mt;
    endtask

    task automatic idle_ex();
        drive_ex(mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_ex();
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_ex();
        dmem.ack = 1'b0;
        dmem.rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if ({mem_stall, mem_regwrite, mem_rd_addr, mem_fwd_data} !== '0) begin errors++; $display("FAIL reset_mem got %h exp 0", {mem_stall, mem_regwrite, mem_rd_addr, mem_fwd_data}); end
        checks++; if ({wb_regwrite, wb_rd_addr, wb_data} !== '0) begin errors++; $display("FAIL reset_wb got %h exp 0", {wb_regwrite, wb_rd_addr, wb_data}); end
        checks++; if ({dmem.req, dmem.we, dmem.addr, dmem.wdata, err} !== '0) begin errors++; $display("FAIL reset_dmem got %h exp 0", {dmem.req, dmem.we, dmem.addr, dmem.wdata, err}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_alu_op();
        logic stall_seen;
        do_reset();
        drive_ex(mk(1'b1, 32'h10, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1 idle_ex();
        @(negedge clk);
        stall_seen = mem_stall;
        checks++; if ({mem_regwrite, mem_rd_addr, mem_fwd_data} !== {1'b1, 5'd5, 32'h10}) begin errors++; $display("FAIL alu_mem got %h exp %h", {mem_regwrite, mem_rd_addr, mem_fwd_data}, {1'b1, 5'd5, 32'h10}); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL alu_wb_early got %b exp 0", wb_regwrite); end
        @(posedge clk); #1;
        @(negedge clk);
        stall_seen = stall_seen | mem_stall;
        checks++; if ({wb_regwrite, wb_rd_addr, wb_data} !== {1'b1, 5'd5, 32'h10}) begin errors++; $display("FAIL alu_wb got %h exp %h", {wb_regwrite, wb_rd_addr, wb_data}, {1'b1, 5'd5, 32'h10}); end
        checks++; if (stall_seen !== 1'b0) begin errors++; $display("FAIL alu_stall got %b exp 0", stall_seen); end
    endtask

    task automatic test_load_wait();
        int stalls;
        do_reset();
        drive_ex(mk(1'b1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive_ex(mk(1'b1, 32'h55, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
        stalls = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            dmem.ack = (c == 3);
            dmem.rdata = (c == 3) ? 32'hDEAD_BEEF : $urandom;
            @(negedge clk);
            stalls += int'(mem_stall);
            checks++; if ({dmem.req, dmem.we, dmem.addr} !== {1'b1, 1'b0, 32'h100}) begin errors++; $display("FAIL lw_req_c%0d got %h exp %h", c, {dmem.req, dmem.we, dmem.addr}, {1'b1, 1'b0, 32'h100}); end
        end
        checks++; if (stalls != 2) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 2", stalls); end
        @(posedge clk); #1;
        dmem.ack = 1'b0;
        idle_ex();
        @(negedge clk);
        checks++; if ({wb_regwrite, wb_rd_addr, wb_data} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin errors++; $display("FAIL lw_wb got %h exp %h", {wb_regwrite, wb_rd_addr, wb_data}, {1'b1, 5'd7, 32'hDEAD_BEEF}); end
        checks++; if ({dmem.req, mem_regwrite, mem_rd_addr} !== {1'b0, 1'b1, 5'd9}) begin errors++; $display("FAIL lw_held_next got %h exp %h", {dmem.req, mem_regwrite, mem_rd_addr}, {1'b0, 1'b1, 5'd9}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if ({wb_regwrite, wb_rd_addr, wb_data} !== {1'b1, 5'd9, 32'h55}) begin errors++; $display("FAIL lw_next_wb got %h exp %h", {wb_regwrite, wb_rd_addr, wb_data}, {1'b1, 5'd9, 32'h55}); end
    endtask

    task automatic test_store_b2b();
        do_reset();
        drive_ex(mk(1'b1, 32'h104, 32'hCAFE, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        @(posedge clk); #1;
        drive_ex(mk(1'b1, 32'h108, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1));
        dmem.ack = 1'b1;
        dmem.rdata = $urandom;
        @(negedge clk);
        checks++; if ({dmem.req, dmem.we, dmem.addr, dmem.wdata} !== {1'b1, 1'b1, 32'h104, 32'hCAFE}) begin errors++; $display("FAIL sw_bus got %h exp %h", {dmem.req, dmem.we, dmem.addr, dmem.wdata}, {1'b1, 1'b1, 32'h104, 32'hCAFE}); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b exp 0", mem_stall); end
        @(posedge clk); #1;
        idle_ex();
        dmem.ack = 1'b0;
        @(negedge clk);
        checks++; if ({dmem.req, dmem.we, dmem.addr, mem_stall} !== {1'b1, 1'b0, 32'h108, 1'b1}) begin errors++; $display("FAIL b2b_lw_bus got %h exp %h", {dmem.req, dmem.we, dmem.addr, mem_stall}, {1'b1, 1'b0, 32'h108, 1'b1}); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL sw_wb_regwrite got %b exp 0", wb_regwrite); end
        @(posedge clk); #1;
        dmem.ack = 1'b1;
        dmem.rdata = 32'h1234_5678;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL b2b_ack_stall got %b exp 0", mem_stall); end
        @(posedge clk); #1;
        dmem.ack = 1'b0;
        @(negedge clk);
        checks++; if ({wb_regwrite, wb_rd_addr, wb_data, dmem.req} !== {1'b1, 5'd3, 32'h1234_5678, 1'b0}) begin errors++; $display("FAIL b2b_lw_wb got %h exp %h", {wb_regwrite, wb_rd_addr, wb_data, dmem.req}, {1'b1, 5'd3, 32'h1234_5678, 1'b0}); end
    endtask

    task automatic test_misaligned();
        logic req_seen;
        do_reset();
        drive_ex(mk(1'b1, 32'h102, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1 idle_ex();
        @(negedge clk);
        req_seen = dmem.req;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b exp 0", mem_stall); end
        @(posedge clk); #1;
        @(negedge clk);
        req_seen = req_seen | dmem.req;
        checks++; if (err !== 2'b01) begin errors++; $display("FAIL mis_err got %b exp 01", err); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL mis_wb_regwrite got %b exp 0", wb_regwrite); end
        repeat (2) begin @(posedge clk); #1; @(negedge clk); req_seen = req_seen | dmem.req; end
        checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL mis_req got %b exp 0", req_seen); end
    endtask

    task automatic test_timeout();
        int req_cnt, stalls;
        do_reset();
        drive_ex(mk(1'b1, 32'h200, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1 idle_ex();
        req_cnt = 0;
        stalls = 0;
        for (int c = 1; c <= 6; c++) begin
            dmem.rdata = $urandom | 32'h1;
            @(negedge clk);
            req_cnt += int'(dmem.req);
            stalls += int'(mem_stall);
            if (c == 5) begin
                checks++; if (err !== 2'b10) begin errors++; $display("FAIL tmo_err got %b exp 10", err); end
                checks++; if ({wb_regwrite, wb_data, mem_stall} !== {1'b0, 32'h0, 1'b0}) begin errors++; $display("FAIL tmo_wb got %h exp 0", {wb_regwrite, wb_data, mem_stall}); end
            end
            @(posedge clk); #1;
        end
        checks++; if (req_cnt != TMO) begin errors++; $display("FAIL tmo_req_cycles got %0d exp %0d", req_cnt, TMO); end
        checks++; if (stalls != TMO - 1) begin errors++; $display("FAIL tmo_stall_cycles got %0d exp %0d", stalls, TMO - 1); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        drive_ex(mk(1'b1, 32'h101, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1;
        drive_ex(mk(1'b1, 32'h300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1 idle_ex();
        @(negedge clk);
        checks++; if ({dmem.req, err} !== {1'b1, 2'b01}) begin errors++; $display("FAIL rstw_pre got %b exp 101", {dmem.req, err}); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({dmem.req, mem_stall, err, mem_regwrite, wb_regwrite} !== '0) begin errors++; $display("FAIL rstw_async got %b exp 0", {dmem.req, mem_stall, err, mem_regwrite, wb_regwrite}); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({dmem.req, wb_regwrite} !== 2'b00) begin errors++; $display("FAIL rstw_after got %b exp 00", {dmem.req, wb_regwrite}); end
        @(posedge clk); #1;
        drive_ex(mk(1'b1, 32'h304, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1));
        @(posedge clk); #1;
        idle_ex();
        dmem.ack = 1'b1;
        dmem.rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        checks++; if ({dmem.req, dmem.addr, mem_stall} !== {1'b1, 32'h304, 1'b0}) begin errors++; $display("FAIL rstw_lw_bus got %h exp %h", {dmem.req, dmem.addr, mem_stall}, {1'b1, 32'h304, 1'b0}); end
        @(posedge clk); #1 dmem.ack = 1'b0;
        @(negedge clk);
        checks++; if ({wb_regwrite, wb_rd_addr, wb_data} !== {1'b1, 5'd10, 32'hA5A5_A5A5}) begin errors++; $display("FAIL rstw_lw_wb got %h exp %h", {wb_regwrite, wb_rd_addr, wb_data}, {1'b1, 5'd10, 32'hA5A5_A5A5}); end
    endtask

    task automatic test_random();
        instr_t cur, in_mem;
        txn_t   txq[$];
        wb_t    wbq[$];
        txn_t   tx, tx_act;
        wb_t    wexp, wgot;
        bit [31:0] mem [bit [31:0]];
        logic   stall_s, active, end_this, exp_stall;
        logic [1:0] exp_err;
        int     wcnt;
        do_reset();
        cur = mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_mem = cur;
        tx_act = '{we: 1'b0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, lat: 1};
        stall_s = 1'b0; active = 1'b0; end_this = 1'b0; exp_err = 2'b00; wcnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            if (end_this) active = 1'b0;
            end_this = 1'b0;
            if (!stall_s) begin
                in_mem = cur;
                if (cur.valid && (cur.mr || cur.mw)) begin
                    if (cur.alu[1:0] != 2'b00) begin
                        exp_err[0] = 1'b1;
                    end else begin
                        if (!mem.exists(cur.alu)) mem[cur.alu] = $urandom;
                        tx = '{we: cur.mw, addr: cur.alu, wdata: cur.rs2, rdata: mem[cur.alu], lat: cur.lat};
                        if (cur.lat > TMO) begin
                            exp_err[1] = 1'b1;
                        end else begin
                            if (cur.mw) mem[cur.alu] = cur.rs2;
                            if (cur.rw) begin wexp.rd = cur.rd; wexp.data = cur.mt ? tx.rdata : cur.alu; wbq.push_back(wexp); end
                        end
                        txq.push_back(tx);
                    end
                end else if (cur.valid && cur.rw) begin
                    wexp.rd = cur.rd; wexp.data = cur.alu; wbq.push_back(wexp);
                end
                cur = (cyc < 560) ? gen() : mk(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            #1;
            drive_ex(cur);
            if (dmem.req) begin
                if (!active) begin
                    checks++;
                    if (txq.size() == 0) begin errors++; $display("FAIL rnd_req got 1 exp 0 (no access pending) cyc %0d", cyc); end
                    else tx_act = txq.pop_front();
                    active = 1'b1;
                    wcnt = 1;
                end else begin
                    wcnt++;
                end
                dmem.ack = (wcnt == tx_act.lat);
                dmem.rdata = dmem.ack ? tx_act.rdata : $urandom;
                end_this = dmem.ack || (wcnt == TMO);
                exp_stall = !dmem.ack && (wcnt != TMO);
            end else begin
                if (active) begin
                    checks++; errors++;
                    $display("FAIL rnd_req_drop got 0 exp 1 cyc %0d", cyc);
                    active = 1'b0;
                end
                dmem.ack = ($urandom_range(0, 3) == 0);
                dmem.rdata = $urandom;
                exp_stall = 1'b0;
            end
            @(negedge clk);
            checks++; if (mem_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall got %b exp %b cyc %0d", mem_stall, exp_stall, cyc); end
            if (active) begin
                checks++; if ({dmem.we, dmem.addr, dmem.wdata} !== {tx_act.we, tx_act.addr, tx_act.wdata}) begin errors++; $display("FAIL rnd_bus got %h exp %h cyc %0d", {dmem.we, dmem.addr, dmem.wdata}, {tx_act.we, tx_act.addr, tx_act.wdata}, cyc); end
            end
            checks++; if ({mem_regwrite, mem_rd_addr, mem_fwd_data} !== {in_mem.valid & in_mem.rw, in_mem.rd, in_mem.alu}) begin errors++; $display("FAIL rnd_mem got %h exp %h cyc %0d", {mem_regwrite, mem_rd_addr, mem_fwd_data}, {in_mem.valid & in_mem.rw, in_mem.rd, in_mem.alu}, cyc); end
            if (wb_regwrite) begin
                checks++;
                if (wbq.size() == 0) begin
                    errors++; $display("FAIL rnd_wb_extra got rd %0d data %h exp none cyc %0d", wb_rd_addr, wb_data, cyc);
                end else begin
                    wgot = wbq.pop_front();
                    if ({wb_rd_addr, wb_data} !== {wgot.rd, wgot.data}) begin errors++; $display("FAIL rnd_wb got %h exp %h cyc %0d", {wb_rd_addr, wb_data}, {wgot.rd, wgot.data}, cyc); end
                end
            end
            stall_s = mem_stall;
        end
        checks++; if (wbq.size() != 0) begin errors++; $display("FAIL rnd_wb_missing got %0d left exp 0", wbq.size()); end
        checks++; if (txq.size() != 0) begin errors++; $display("FAIL rnd_txn_missing got %0d left exp 0", txq.size()); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL rnd_err got %b exp %b", err, exp_err); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        dmem.ack = 1'b0;
        dmem.rdata = '0;
        idle_ex();
        test_reset();
        test_alu_op();
        test_load_wait();
        test_store_b2b();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
